// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding,
// parity-mode constants and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Zero-extending the payload to 16 bits leaves its XOR unchanged.
  function automatic logic parity_of(
    input logic [15:0] d,
    input logic        odd
  );
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time generator: counts 0..CLKS_PER_BIT-1 and
// pulses tick on the last count; clear holds it at 0.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] MAX = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == MAX) && !clear;

  // Free-running bit-time counter, restarted by clear.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start, LSB-first data,
// optional parity, 1 or 2 stop bits, valid/ready intake.
module uart_tx_param #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done
);

  import uart_pkg::*;

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic ODD =
    (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  uart_state_e       state_q, state_d;
  logic              tx_q, tx_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [BW-1:0]     cnt_q, cnt_d;
  logic              par_q, par_d;
  logic              done_q, done_d;
  logic              rdy_q, rdy_d;
  logic              tick;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(state_q == IDLE),
    .tick (tick)
  );

  // Next-state, next-bit and bit/stop counting.
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_valid && rdy_q) begin
          state_d = START;
          tx_d    = 1'b0;
          sh_d    = tx_data;
          cnt_d   = '0;
          par_d   = parity_of(16'(tx_data), ODD);
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          tx_d    = sh_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (cnt_q == LAST_BIT) begin
            cnt_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
            sh_d  = sh_q >> 1;
            tx_d  = sh_q[1];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          if (cnt_q == LAST_STOP) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
    rdy_d = (state_d == IDLE);
  end

  // State and output registers; reset wins over acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      sh_q    <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
    end
  end

  assign tx       = tx_q;
  assign tx_busy  = (state_q != IDLE);
  assign tx_done  = done_q;
  assign tx_ready = rdy_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four parameterisations,
// table vectors, corner sequences and random frames.
module tb_uart_tx_param;

  localparam int CPB = 4;
  localparam int PE[4] = '{0, 1, 1, 0};
  localparam int PO[4] = '{0, 0, 1, 0};
  localparam int SB[4] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst   [4];
  logic       valid [4];
  logic [7:0] dat   [4];
  logic       tx    [4];
  logic       rdy   [4];
  logic       busy  [4];
  logic       done  [4];

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  uart_tx_param #(
    .DATA_W(8), .CLKS_PER_BIT(CPB),
    .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
  ) u0 (
    .clk(clk), .rst(rst[0]), .tx_valid(valid[0]),
    .tx_data(dat[0]), .tx_ready(rdy[0]), .tx(tx[0]),
    .tx_busy(busy[0]), .tx_done(done[0])
  );

  uart_tx_param #(
    .DATA_W(8), .CLKS_PER_BIT(CPB),
    .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
  ) u1 (
    .clk(clk), .rst(rst[1]), .tx_valid(valid[1]),
    .tx_data(dat[1]), .tx_ready(rdy[1]), .tx(tx[1]),
    .tx_busy(busy[1]), .tx_done(done[1])
  );

  uart_tx_param #(
    .DATA_W(8), .CLKS_PER_BIT(CPB),
    .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)
  ) u2 (
    .clk(clk), .rst(rst[2]), .tx_valid(valid[2]),
    .tx_data(dat[2]), .tx_ready(rdy[2]), .tx(tx[2]),
    .tx_busy(busy[2]), .tx_done(done[2])
  );

  uart_tx_param #(
    .DATA_W(8), .CLKS_PER_BIT(CPB),
    .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)
  ) u3 (
    .clk(clk), .rst(rst[3]), .tx_valid(valid[3]),
    .tx_data(dat[3]), .tx_ready(rdy[3]), .tx(tx[3]),
    .tx_busy(busy[3]), .tx_done(done[3])
  );

  typedef struct {
    int          k;
    logic [7:0]  d;
    logic [15:0] bits;
    int          nb;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input int k,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s inst%0d: got %0h want %0h",
                  nm, k, act, exp);
  endtask

  // Line bits in transmit order, bit 0 first.
  function automatic logic [15:0] model(
    input logic [7:0] d, input int pe, input int po,
    input int sb, output int nb);
    logic [15:0] b;
    int p;
    b = '1;
    p = 0;
    b[p] = 1'b0;
    p++;
    for (int j = 0; j < 8; j++) begin
      b[p] = d[j];
      p++;
    end
    if (pe != 0) begin
      b[p] = (($countones(d) % 2) != po);
      p++;
    end
    for (int s = 0; s < sb; s++) begin
      b[p] = 1'b1;
      p++;
    end
    nb = p;
    return b;
  endfunction

  task automatic run_frame(input int k, input logic [7:0] d,
                           input logic [15:0] bits,
                           input int nb, input bit keep,
                           input bit toggle);
    int n;
    n = 0;
    while (rdy[k] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", k, rdy[k], 1);
    valid[k] = 1'b1;
    dat[k]   = d;
    @(negedge clk);
    if (!keep) valid[k] = 1'b0;
    for (int i = 0; i < nb * CPB; i++) begin
      chk("tx_bit", k, tx[k], bits[i / CPB]);
      chk("busy", k, busy[k], 1);
      chk("ready_in_frame", k, rdy[k], 0);
      chk("done_early", k, done[k], 0);
      if (toggle) begin
        dat[k] = 8'($urandom);
        if (!keep)
          valid[k] = (i < nb * CPB - 1) ? 1'($urandom) : 1'b0;
      end
      @(negedge clk);
    end
    chk("done_pulse", k, done[k], 1);
    chk("done_tx_idle", k, tx[k], 1);
    chk("done_busy", k, busy[k], 0);
    chk("done_ready", k, rdy[k], 1);
  endtask

  initial begin
    logic [15:0] b;
    logic [7:0]  d;
    int          nb;
    int          k;

    tbl[0] = '{0, 8'hA5, 16'h034A, 10};
    tbl[1] = '{1, 8'h07, 16'h060E, 11};
    tbl[2] = '{1, 8'h00, 16'h0400, 11};
    tbl[3] = '{2, 8'h00, 16'h0600, 11};
    tbl[4] = '{2, 8'h07, 16'h040E, 11};
    tbl[5] = '{3, 8'hFF, 16'h07FE, 11};

    for (int i = 0; i < 4; i++) begin
      rst[i]   = 1'b1;
      valid[i] = 1'b0;
      dat[i]   = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("rst_tx", i, tx[i], 1);
      chk("rst_busy", i, busy[i], 0);
      chk("rst_done", i, done[i], 0);
      chk("rst_ready", i, rdy[i], 0);
      rst[i] = 1'b0;
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      chk("ready_after_rst", i, rdy[i], 1);

    for (int i = 0; i < 6; i++)
      run_frame(tbl[i].k, tbl[i].d, tbl[i].bits,
                tbl[i].nb, 1'b0, 1'b0);

    b = model(8'h12, 0, 0, 1, nb);
    run_frame(0, 8'h12, b, nb, 1'b1, 1'b0);
    b = model(8'h34, 0, 0, 1, nb);
    run_frame(0, 8'h34, b, nb, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b_no_extra", 0, busy[0], 0);

    d = 8'h5A;
    b = model(d, 0, 0, 1, nb);
    valid[0] = 1'b1;
    dat[0]   = d;
    @(negedge clk);
    valid[0] = 1'b0;
    for (int i = 0; i < 18; i++) begin
      chk("pre_rst_tx", 0, tx[0], b[i / CPB]);
      @(negedge clk);
    end
    rst[0] = 1'b1;
    @(negedge clk);
    chk("midrst_tx", 0, tx[0], 1);
    chk("midrst_busy", 0, busy[0], 0);
    chk("midrst_done", 0, done[0], 0);
    chk("midrst_ready", 0, rdy[0], 0);
    rst[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_done", 0, done[0], 0);
      chk("post_rst_tx", 0, tx[0], 1);
    end
    b = model(8'h3C, 0, 0, 1, nb);
    run_frame(0, 8'h3C, b, nb, 1'b0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      k = int'($urandom_range(0, 3));
      d = 8'($urandom);
      b = model(d, PE[k], PO[k], SB[k], nb);
      run_frame(k, d, b, nb, 1'b0, n[0]);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
